// File: rtl/note_sched_pkg.sv
// Shared types and constants for the note scheduler and its lane-pattern ROM.
package note_sched_pkg;

  localparam int NUM_LANES   = 4;
  localparam int DRAIN_TICKS = 8;

  typedef logic [NUM_LANES-1:0] lane_mask_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNTIN = 3'd1,
    S_PLAY    = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } sched_state_t;

  // Scroll period in clocks for a speed setting, clamped so a tiny base never yields zero.
  function automatic int tick_period(input int base, input logic [1:0] spd);
    int p;
    p = base >> spd;
    return (p < 1) ? 1 : p;
  endfunction

endpackage

// File: rtl/note_pattern_rom.sv
// 256x4 lane-pattern ROM, synchronous read: data is valid the cycle after en.
module note_pattern_rom
  import note_sched_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  logic [7:0] addr,
  output lane_mask_t data
);

  // Steps 0 and 1 are fixed openers; the rest follow a nibble-sum pattern.
  function automatic lane_mask_t pattern_at(input logic [7:0] a);
    lane_mask_t d;
    case (a)
      8'd0:    d = 4'b1001;
      8'd1:    d = 4'b0100;
      default: d = a[3:0] + a[7:4];
    endcase
    return d;
  endfunction

  // Registered read port
  always_ff @(posedge clk) begin
    if (en) begin
      data <= pattern_at(addr);
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Rhythm-game note scheduler: scroll ticks, count-in, pattern playback and drain.
// Build option: NOTE_SCHED_LOOP_EN makes playback wrap forever instead of draining.
module note_scheduler
  import note_sched_pkg::*;
#(
  parameter int TICK_BASE = 512,
  parameter int SONG_LEN  = 64,
  parameter int COUNTIN   = 8
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] speed,
  output logic       scroll,
  output logic [3:0] spawn,
  output logic [7:0] step,
  output logic       busy,
  output logic       done
);

  localparam int                CW           = $clog2(TICK_BASE + 1);
  localparam logic [CW-1:0]     CNT_ZERO     = CW'(0);
  localparam logic [CW-1:0]     CNT_ONE      = CW'(1);
  localparam logic [15:0]       COUNTIN_LAST = 16'(COUNTIN - 1);
  localparam logic [15:0]       DRAIN_LAST   = 16'(DRAIN_TICKS - 1);
  localparam logic [7:0]        LAST_STEP    = 8'(SONG_LEN - 1);

  sched_state_t  state_r, state_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic [CW-1:0] period_r, period_nxt;
  logic [CW-1:0] speed_period_s;
  logic [15:0]   ticks_r, ticks_nxt;
  logic [7:0]    step_r, step_nxt;
  logic          pend_r;
  logic          run_s;
  logic          tick_s;
  logic          rom_en_s;
  lane_mask_t    rom_data_s;

  assign speed_period_s = CW'(tick_period(TICK_BASE, speed));

  // Pause is a level freeze; it also wins over a coinciding reload.
  assign run_s    = ((state_r == S_COUNTIN) || (state_r == S_PLAY) || (state_r == S_DRAIN)) && !pause;
  assign tick_s   = run_s && (cnt_r == (period_r - CNT_ONE));
  assign rom_en_s = tick_s && (state_r == S_PLAY);

  assign scroll = tick_s;
  assign spawn  = pend_r ? rom_data_s : 4'b0000;
  assign step   = step_r;
  assign busy   = (state_r != S_IDLE);
  assign done   = (state_r == S_DONE);

  note_pattern_rom u_rom (
    .clk  (clk),
    .en   (rom_en_s),
    .addr (step_r),
    .data (rom_data_s)
  );

  // Next-state, tick counter, speed latch and step sequencing
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
    period_nxt = period_r;
    ticks_nxt  = ticks_r;
    step_nxt   = step_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt  = (COUNTIN == 0) ? S_PLAY : S_COUNTIN;
          cnt_nxt    = CNT_ZERO;
          period_nxt = speed_period_s;
          ticks_nxt  = 16'd0;
          step_nxt   = 8'd0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_COUNTIN, S_PLAY, S_DRAIN: begin
        if (tick_s) begin
          cnt_nxt    = CNT_ZERO;
          period_nxt = speed_period_s;
          ticks_nxt  = ticks_r + 16'd1;
          case (state_r)
            S_COUNTIN: begin
              if (ticks_r == COUNTIN_LAST) begin
                state_nxt = S_PLAY;
                ticks_nxt = 16'd0;
              end else begin
                state_nxt = S_COUNTIN;
              end
            end
            S_PLAY: begin
              if (step_r == LAST_STEP) begin
`ifdef NOTE_SCHED_LOOP_EN
                step_nxt = 8'd0;
`else
                step_nxt  = step_r + 8'd1;
                state_nxt = S_DRAIN;
                ticks_nxt = 16'd0;
`endif
              end else begin
                step_nxt = step_r + 8'd1;
              end
            end
            S_DRAIN: begin
              if (ticks_r == DRAIN_LAST) begin
                state_nxt = S_DONE;
              end else begin
                state_nxt = S_DRAIN;
              end
            end
            default: state_nxt = S_IDLE;
          endcase
        end else if (run_s) begin
          cnt_nxt = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State registers; reset aborts any song without a done pulse
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_r  <= S_IDLE;
      cnt_r    <= CNT_ZERO;
      period_r <= CW'(TICK_BASE);
      ticks_r  <= 16'd0;
      step_r   <= 8'd0;
      pend_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
      period_r <= period_nxt;
      ticks_r  <= ticks_nxt;
      step_r   <= step_nxt;
      pend_r   <= rom_en_s;
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboard bench for note_scheduler: reference model predicts scroll/spawn/done events.
module tb_note_scheduler;

  localparam int P_BASE    = 8;
  localparam int P_SONG    = 4;
  localparam int P_COUNTIN = 2;
  localparam int K_SCROLL  = 0;
  localparam int K_SPAWN   = 1;
  localparam int K_DONE    = 2;

  logic       clk;
  logic       RST;
  logic       start;
  logic       pause;
  logic [1:0] speed;
  logic       scroll;
  logic [3:0] spawn;
  logic [7:0] step;
  logic       busy;
  logic       done;

  note_scheduler #(.TICK_BASE(P_BASE), .SONG_LEN(P_SONG), .COUNTIN(P_COUNTIN)) dut (
    .clk(clk), .RST(RST), .start(start), .pause(pause), .speed(speed),
    .scroll(scroll), .spawn(spawn), .step(step), .busy(busy), .done(done)
  );

  typedef struct {int cyc; int kind; int val; int stp;} ev_t;

  ev_t q[$];
  int  log_scroll[$];
  int  log_spawn_cyc[$];
  int  log_spawn_val[$];
  int  log_spawn_stp[$];
  int  log_done[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  exp_busy = 0;
  int  exp_step = 0;
  int  m_phase = 0;
  int  m_left = 0;
  int  m_ticks = 0;
  int  m_step = 0;
  int  m_pend = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rom_ref(input int a);
    if (a == 0) return 9;
    if (a == 1) return 4;
    return ((a % 16) + (a / 16)) % 16;
  endfunction

  function automatic int per(input int spd);
    int p;
    p = P_BASE >> spd;
    return (p < 1) ? 1 : p;
  endfunction

  function automatic int at_scroll(input int i);
    return (i < log_scroll.size()) ? log_scroll[i] : -1000;
  endfunction
  function automatic int at_sp_cyc(input int i);
    return (i < log_spawn_cyc.size()) ? log_spawn_cyc[i] : -1000;
  endfunction
  function automatic int at_sp_val(input int i);
    return (i < log_spawn_val.size()) ? log_spawn_val[i] : -1;
  endfunction
  function automatic int at_sp_stp(input int i);
    return (i < log_spawn_stp.size()) ? log_spawn_stp[i] : -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Song-level reference: countdown to next tick, phase of the song, pattern index.
  task automatic model_step();
    bit sc;
    if (!RST) begin
      m_phase = 0; m_step = 0; m_pend = 0; m_left = 0; m_ticks = 0;
      exp_busy = 0; exp_step = 0;
      return;
    end
    sc = (m_phase >= 1) && (m_phase <= 3) && !pause && (m_left == 1);
    if (sc) q.push_back('{cyc, K_SCROLL, 0, 0});
    if (m_pend != 0) q.push_back('{cyc, K_SPAWN, m_pend, m_step});
    if (m_phase == 4) q.push_back('{cyc, K_DONE, 0, 0});
    exp_busy = (m_phase != 0);
    exp_step = m_step;
    m_pend = 0;
    if (m_phase == 0) begin
      if (start) begin
        m_phase = (P_COUNTIN > 0) ? 1 : 2;
        m_left = per(speed); m_ticks = 0; m_step = 0;
      end
    end else if (m_phase == 4) begin
      m_phase = 0;
    end else if (!pause) begin
      if (sc) begin
        m_left = per(speed);
        m_ticks++;
        if (m_phase == 1) begin
          if (m_ticks == P_COUNTIN) begin m_phase = 2; m_ticks = 0; end
        end else if (m_phase == 2) begin
          m_pend = rom_ref(m_step);
          m_step = (m_step + 1) % 256;
          if (m_step == P_SONG) begin
`ifdef NOTE_SCHED_LOOP_EN
            m_step = 0;
`else
            m_phase = 3; m_ticks = 0;
`endif
          end
        end else if (m_ticks == 8) begin
          m_phase = 4;
        end
      end else begin
        m_left--;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    #3;
    model_step();
  end

  task automatic check_event(input int kind, input int val, input int stp);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event: DUT kind %0d val %0d at cycle %0d, none expected", kind, val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val || e.stp != stp) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d val %0d step %0d, expected kind %0d cyc %0d val %0d step %0d",
                 kind, cyc, val, stp, e.kind, e.cyc, e.val, e.stp);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event
  initial forever begin
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing: kind %0d expected at cycle %0d, not seen by %0d", q[0].kind, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (scroll) begin
      log_scroll.push_back(cyc);
      check_event(K_SCROLL, 0, 0);
    end
    if (spawn != 4'b0000) begin
      log_spawn_cyc.push_back(cyc);
      log_spawn_val.push_back(int'(spawn));
      log_spawn_stp.push_back(int'(step));
      check_event(K_SPAWN, int'(spawn), int'(step));
    end
    if (done) begin
      log_done.push_back(cyc);
      check_event(K_DONE, 0, 0);
    end
    checks++;
    if (int'(busy) != exp_busy || int'(step) != exp_step) begin
      errors++;
      $display("FAIL status: cycle %0d busy %0d step %0d, expected busy %0d step %0d",
               cyc, busy, step, exp_busy, exp_step);
    end
  end

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    log_scroll.delete(); log_spawn_cyc.delete(); log_spawn_val.delete();
    log_spawn_stp.delete(); log_done.delete();
  endtask

  task automatic pulse_start(output int c0);
    start = 1'b1;
    c0 = cyc;
    next();
    start = 1'b0;
  endtask

  task automatic wait_scroll();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (scroll) return;
    end
    chk("wait_scroll_timeout", 0, 1);
  endtask

  task automatic end_song();
    pause = 1'b0;
`ifdef NOTE_SCHED_LOOP_EN
    RST = 1'b0;
    next(); next();
    RST = 1'b1;
    next();
`else
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      next();
    end
`endif
    chk("end_idle", int'(busy), 0);
    next();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    RST = 1'b0; start = 1'b0; pause = 1'b0; speed = 2'd0;
    next(); next();
    chk("rst_scroll", int'(scroll), 0);
    chk("rst_spawn", int'(spawn), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_step", int'(step), 0);
    RST = 1'b1;
    next();

    // A: basic timing, pattern data, drain and done
    clear_logs();
    pulse_start(c0);
    repeat (60) next();
    chk("scroll1_at", at_scroll(0) - c0, 8);
    chk("scroll2_at", at_scroll(1) - c0, 16);
    chk("scroll3_at", at_scroll(2) - c0, 24);
    chk("spawn1_at", at_sp_cyc(0) - c0, 25);
    chk("spawn1_val", at_sp_val(0), 9);
    chk("spawn1_step", at_sp_stp(0), 1);
    chk("spawn2_at", at_sp_cyc(1) - c0, 33);
    chk("spawn2_val", at_sp_val(1), 4);
    chk("spawn2_step", at_sp_stp(1), 2);
`ifdef NOTE_SCHED_LOOP_EN
    chk("wrap_step", at_sp_stp(3), 0);
    chk("wrap_val", at_sp_val(4), 9);
    chk("wrap_step1", at_sp_stp(4), 1);
    chk("loop_no_done", log_done.size(), 0);
`else
    for (int i = 0; i < 200; i++) begin
      if (log_done.size() > 0) break;
      next();
    end
    next(); next();
    chk("done_count", log_done.size(), 1);
    chk("spawn_count", log_spawn_cyc.size(), 4);
    n = 0;
    foreach (log_scroll[i]) if (log_scroll[i] > at_sp_cyc(3)) n++;
    chk("drain_scrolls", n, 8);
    chk("done_after_last", (log_done.size() > 0 ? log_done[0] : 0) - at_scroll(log_scroll.size() - 1), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_step", int'(step), 4);
`endif
    end_song();

    // B: start ignored in PLAY, pause stretches a period
    clear_logs();
    pulse_start(c0);
    wait_scroll(); wait_scroll(); wait_scroll();
    next(); start = 1'b1;
    next(); start = 1'b0;
    repeat (4) next();
    pause = 1'b1;
    repeat (20) next();
    pause = 1'b0;
    wait_scroll();
    chk("pause_prev_period", at_scroll(2) - at_scroll(1), 8);
    chk("pause_period", at_scroll(3) - at_scroll(2), 28);
    end_song();

    // C: speed change mid-period
    clear_logs();
    speed = 2'd0;
    pulse_start(c0);
    wait_scroll();
    repeat (3) next();
    speed = 2'd2;
    wait_scroll(); wait_scroll(); wait_scroll();
    chk("speed_next", at_scroll(1) - at_scroll(0), 8);
    chk("speed_after1", at_scroll(2) - at_scroll(1), 2);
    chk("speed_after2", at_scroll(3) - at_scroll(2), 2);
    end_song();
    speed = 2'd0;

    // D: randomized pause, speed and start traffic
    for (int it = 0; it < 4; it++) begin
      speed = 2'($urandom_range(0, 3));
      pulse_start(c0);
      for (int i = 0; i < 250; i++) begin
        pause = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 15) == 0) speed = 2'($urandom_range(0, 3));
        start = ($urandom_range(0, 31) == 0);
        next();
      end
      start = 1'b0;
      end_song();
    end
    speed = 2'd0;

    // E: asynchronous reset in the cycle a spawn is showing
    clear_logs();
    pulse_start(c0);
    wait_scroll(); wait_scroll(); wait_scroll();
    next();
    RST = 1'b0;
    #1;
    chk("arst_scroll", int'(scroll), 0);
    chk("arst_spawn", int'(spawn), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_step", int'(step), 0);
    repeat (3) next();
    RST = 1'b1;
    repeat (20) next();
    chk("arst_no_done", log_done.size(), 0);
    chk("arst_idle", int'(busy), 0);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
